// File: rtl/count_capture_pkg.sv
// count_capture_pkg
//   Shared defaults and the capture FSM state type for count_capture.
//   No ports; imported by count_capture and count_capture_fifo.
package count_capture_pkg;

   localparam int DEF_WIDTH = 12;   // counter value width
   localparam int DEF_DEPTH = 4;    // capture FIFO entries (power of 2, >= 2)
   localparam int DEF_HOLD  = 8;    // event holdoff length in cycles (>= 1)

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_HOLDOFF = 2'd2
   } cap_state_t;

endpackage

// File: rtl/count_capture_fifo.sv
// count_capture_fifo
//   First-word-fall-through capture FIFO with sticky overflow flag.
//   A push into an empty FIFO shows up at the head one cycle later.
// Ports:
//   clock, rst      rising-edge clock, async active-low reset
//   push, push_data write request and {wrap, count} entry
//   push_ok         push is accepted this cycle (not full, or popping)
//   pop_req         consumer ready; a pop only happens when head_valid
//   head, head_valid FIFO head entry (zero while empty) and its valid
//   level           occupancy, 0..DEPTH
//   ovf, clr_ovf    sticky overflow flag and its synchronous clear
module count_capture_fifo
   import count_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH:0]         push_data,
   output logic                   push_ok,
   input  logic                   pop_req,
   output logic [WIDTH:0]         head,
   output logic                   head_valid,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ovf,
   input  logic                   clr_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH:0] mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic           full, pop, drop;

   assign head_valid = (level != '0);
   assign full       = (level == LW'(DEPTH));
   assign pop        = head_valid & pop_req;
   // When full, a same-cycle pop frees the slot being written.
   assign push_ok    = push & (~full | pop);
   assign drop       = push & full & ~pop;
   assign head       = head_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         // A new overflow wins over a clear in the same cycle.
         if (drop)         ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/count_capture.sv
// count_capture
//   Captures an upstream counter value on an asynchronous external event,
//   tagging each capture with whether the counter wrapped since the last
//   accepted capture. Captures queue in a FWFT FIFO.
// Ports:
//   clock, rst      rising-edge clock, async active-low reset
//   d_in, d_en      upstream counter value and its enable (qualifies wrap)
//   arm             capture enable
//   evt             asynchronous event input
//   cap_data/cap_wrap/cap_valid, cap_ready   FIFO head and handshake
//   level           FIFO occupancy
//   ovf, clr_ovf    sticky overflow flag and synchronous clear
module count_capture
   import count_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int HOLD  = DEF_HOLD
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       d_in,
   input  logic                   d_en,
   input  logic                   arm,
   input  logic                   evt,
   output logic [WIDTH-1:0]       cap_data,
   output logic                   cap_wrap,
   output logic                   cap_valid,
   input  logic                   cap_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ovf,
   input  logic                   clr_ovf
);

   localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

   cap_state_t     state, state_nxt;
   logic           evt_s1, evt_s2, evt_q, evt_rise;
   logic [WIDTH-1:0] d_prev;
   logic           wrap_now, wrap_pend;
   logic [HCW-1:0] hold_cnt;
   logic           push, push_ok;
   logic [WIDTH:0] head;

   // evt_s1/evt_s2 form the synchronizer; evt_q only serves edge detection,
   // so the pushed value is d_in at the second edge after evt is sampled.
   assign evt_rise = evt_s2 & ~evt_q;
   assign wrap_now = d_en & (d_prev == '1) & (d_in == '0);
   assign push     = (state == ST_ARMED) & evt_rise;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         evt_s1    <= 1'b0;
         evt_s2    <= 1'b0;
         evt_q     <= 1'b0;
         d_prev    <= '0;
         wrap_pend <= 1'b0;
         hold_cnt  <= '0;
         state     <= ST_IDLE;
      end else begin
         evt_s1 <= evt;
         evt_s2 <= evt_s1;
         evt_q  <= evt_s2;
         d_prev <= d_in;
         state  <= state_nxt;
         // A same-cycle wrap is folded into the accepted entry, so the
         // flag simply clears; a dropped push keeps any pending wrap.
         if (push_ok)       wrap_pend <= 1'b0;
         else if (wrap_now) wrap_pend <= 1'b1;
         if (state == ST_HOLDOFF) hold_cnt <= hold_cnt + HCW'(1);
         else                     hold_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (arm) state_nxt = ST_ARMED;
         ST_ARMED:   if (evt_rise)  state_nxt = ST_HOLDOFF;
                     else if (!arm) state_nxt = ST_IDLE;
         ST_HOLDOFF: if (hold_cnt == HOLD_LAST) state_nxt = arm ? ST_ARMED : ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clock      (clock),
      .rst        (rst),
      .push       (push),
      .push_data  ({wrap_pend | wrap_now, d_in}),
      .push_ok    (push_ok),
      .pop_req    (cap_ready),
      .head       (head),
      .head_valid (cap_valid),
      .level      (level),
      .ovf        (ovf),
      .clr_ovf    (clr_ovf)
   );

   assign cap_wrap = head[WIDTH];
   assign cap_data = head[WIDTH-1:0];

endmodule
